// File: rtl/lcd_bus_controller.sv
// HD44780 bus write sequencer: SETUP -> EN_HI -> HOLD -> WAIT, one shared down-counter.
// Define LCD_BUSY_POLL_EN to replace the fixed WAIT with busy-flag read polling.
module lcd_bus_controller #(
  parameter int SETUP_CYC     = 3,
  parameter int EN_HIGH_CYC   = 12,
  parameter int HOLD_CYC      = 1,
  parameter int WAIT_CYC      = 2000,
  parameter int LONG_WAIT_CYC = 80000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] iDATA,
  input  logic       iRS,
  input  logic       iStart,
  output logic       oBusy,
  output logic       oDone,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_RS
);

  localparam int CNT_W = ($clog2(LONG_WAIT_CYC + 1) > 17) ? $clog2(LONG_WAIT_CYC + 1) : 17;

  // Counter reload values: a state lasting N cycles loads N-1 and leaves at zero.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    EN_HI,
    HOLD,
    WAIT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       data_q;
  logic             accept, finish;

`ifdef LCD_BUSY_POLL_EN
  logic             rw_q, oe_q, polling, busy_flag, start_read;

  assign LCD_RW   = rw_q;
  assign LCD_DATA = oe_q ? data_q : 8'hzz;
`else
  logic             is_long;

  // Clear display (0x01) and return home (0x02/0x03) need the long execution delay.
  assign is_long  = !LCD_RS && (data_q[7:2] == 6'd0);
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    finish  = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    start_read = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (iStart) begin
          accept  = 1'b1;
          state_n = SETUP;
          cnt_n   = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = EN_HI;
          cnt_n   = EN_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      EN_HI: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = HOLD_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
`ifdef LCD_BUSY_POLL_EN
          if (polling && !busy_flag) begin
            finish = 1'b1;
          end else begin
            start_read = 1'b1;
            state_n    = SETUP;
            cnt_n      = SETUP_LD;
          end
`else
          state_n = WAIT;
          cnt_n   = is_long ? LONG_LD : WAIT_LD;
`endif
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          finish = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (finish) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      LCD_EN <= 1'b0;
      LCD_RS <= 1'b0;
      data_q <= 8'h00;
      oBusy  <= 1'b0;
      oDone  <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      rw_q      <= 1'b0;
      oe_q      <= 1'b1;
      polling   <= 1'b0;
      busy_flag <= 1'b0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state  <= state_n;
      cnt    <= cnt_n;
      LCD_EN <= (state_n == EN_HI);
      oBusy  <= (state_n != IDLE);
      oDone  <= finish;
      if (accept) begin
        LCD_RS <= iRS;
        data_q <= iDATA;
      end
`ifdef LCD_BUSY_POLL_EN
      if (accept) begin
        rw_q <= 1'b0;
        oe_q <= 1'b1;
      end
      if (start_read) begin
        LCD_RS  <= 1'b0;
        rw_q    <= 1'b1;
        oe_q    <= 1'b0;
        polling <= 1'b1;
      end
      if (finish) begin
        rw_q    <= 1'b0;
        oe_q    <= 1'b1;
        polling <= 1'b0;
      end
      // DB7 is valid late in the EN pulse; take it on the final EN_HI cycle.
      if (state == EN_HI && cnt == '0) begin
        busy_flag <= LCD_DATA[7];
      end
`endif
    end
  end

endmodule
